// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole score display: game-state codes,
// blank/dash segment patterns and the active-low 0-9 glyph table.
package wam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GAMEPLAY   = 3'd1,
        ST_END_SCREEN = 3'd2
    } game_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low cathodes, seg[0]=a ... seg[6]=g.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/wam_bin2bcd.sv
// Sequential 7-bit binary to 3-digit BCD converter (shift-add-3).
// One load cycle, then 7 iterations; done pulses with bcd updated together.
module wam_bin2bcd
    import wam_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    typedef enum logic {CV_IDLE, CV_RUN} cv_state_t;

    cv_state_t   cv_state;
    logic [18:0] sr;
    logic [18:0] sr_adj;
    logic [18:0] sr_next;
    logic [2:0]  iter;

    always_comb begin
        sr_adj = sr;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sr[7 + 4*i +: 4] >= 4'd5)
                sr_adj[7 + 4*i +: 4] = sr[7 + 4*i +: 4] + 4'd3;
        end
        sr_next = {sr_adj[17:0], 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cv_state <= CV_IDLE;
            sr       <= '0;
            iter     <= '0;
            done     <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            case (cv_state)
                CV_IDLE: begin
                    if (start) begin
                        sr       <= {12'd0, bin};
                        iter     <= '0;
                        cv_state <= CV_RUN;
                    end
                end
                default: begin
                    sr   <= sr_next;
                    iter <= iter + 3'd1;
                    if (iter == 3'd6) begin
                        done     <= 1'b1;
                        bcd      <= sr_next[18:7];
                        cv_state <= CV_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/wam_score_display.sv
// Four-digit multiplexed 7-segment display of lives and score.
// Optional END_SCREEN blinking is enabled by defining WAM_DISP_BLINK_EN.
module wam_score_display
    import wam_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] score,
    input  logic [1:0] lives,
    input  logic [2:0] state,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);

    game_state_t cur_state;
    logic        busy;
    logic        conv_start;
    logic        conv_done;
    logic [11:0] conv_bcd;
    logic [11:0] disp_bcd;
    logic [6:0]  last_score;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]  scan_idx;
    logic [6:0]  seg_next;
    logic        blank_all;

    assign dp = 1'b1;

    always_comb begin
        case (state)
            ST_GAMEPLAY:   cur_state = ST_GAMEPLAY;
            ST_END_SCREEN: cur_state = ST_END_SCREEN;
            default:       cur_state = ST_IDLE;
        endcase
    end

    assign conv_start = !busy && (score != last_score);

    wam_bin2bcd u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (score),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            last_score <= '0;
            disp_bcd   <= '0;
        end else if (conv_start) begin
            busy       <= 1'b1;
            last_score <= score;
        end else if (conv_done) begin
            busy     <= 1'b0;
            disp_bcd <= conv_bcd;
        end
    end

    always_comb begin
        seg_next = SEG_DASH;
        if (cur_state != ST_IDLE) begin
            case (scan_idx)
                2'd0: seg_next = glyph(disp_bcd[3:0]);
                2'd1: seg_next = (disp_bcd[11:4] == 8'd0) ? SEG_BLANK : glyph(disp_bcd[7:4]);
                2'd2: seg_next = (disp_bcd[11:8] == 4'd0) ? SEG_BLANK : glyph(disp_bcd[11:8]);
                default: seg_next = glyph({2'b00, lives});
            endcase
        end
    end

`ifdef WAM_DISP_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_DIV);

    logic [BW-1:0] blink_cnt;
    logic          blink_off;
    logic          in_end_q;

    // The entry cycle itself is count 0, so the visible phase lasts exactly BLINK_DIV.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
            in_end_q  <= 1'b0;
        end else begin
            in_end_q <= (cur_state == ST_END_SCREEN);
            if (cur_state != ST_END_SCREEN) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (!in_end_q) begin
                blink_cnt <= BW'(1);
                blink_off <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign blank_all = (cur_state == ST_END_SCREEN) && blink_off;
`else
    assign blank_all = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
        end else begin
            if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
            an  <= blank_all ? 4'b1111 : ~(4'b0001 << scan_idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_wam_score_display.sv
// Directed self-checking bench for wam_score_display (REFRESH_DIV=4, BLINK_DIV=8).
// Blink expectations follow WAM_DISP_BLINK_EN when it is defined for the build.
module tb_wam_score_display;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] score = '0;
    logic [1:0] lives = '0;
    logic [2:0] state = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] cap [4];
    int         cap_badan;

    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12, G7 = 7'h78, G9 = 7'h10;
    localparam logic [6:0] BLK = 7'h7F, DSH = 7'h3F;

    always #5 clk = ~clk;

    wam_score_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .lives (lives),
        .state (state),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    // Records the last segment pattern seen on each digit over n cycles.
    task automatic capture(input int n);
        for (int i = 0; i < 4; i++) cap[i] = 'x;
        cap_badan = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: cap[0] = seg;
                4'b1101: cap[1] = seg;
                4'b1011: cap[2] = seg;
                4'b0111: cap[3] = seg;
                default: cap_badan++;
            endcase
        end
    endtask

    task automatic test_reset;
        logic [6:0] exp [4];
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL reset_an got=%b exp=1111", an); end
        vectors++;
        if (seg !== BLK) begin miscompares++; $display("FAIL reset_seg got=%h exp=%h", seg, BLK); end
        vectors++;
        if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp got=%b exp=1", dp); end
        score = 7'd0; state = 3'd0;
        reset = 1'b0;
        capture(20);
        exp = '{DSH, DSH, DSH, DSH};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap[i] !== exp[i]) begin miscompares++; $display("FAIL idle_d%0d got=%h exp=%h", i, cap[i], exp[i]); end
        end
        vectors++;
        if (cap_badan !== 0) begin miscompares++; $display("FAIL idle_onehot got=%0d exp=0", cap_badan); end
        // Undefined state code shows dashes too, even with a score loaded.
        score = 7'd55; state = 3'd5;
        repeat (16) @(negedge clk);
        capture(16);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap[i] !== DSH) begin miscompares++; $display("FAIL badstate_d%0d got=%h exp=%h", i, cap[i], DSH); end
        end
    endtask

    task automatic test_scan_order;
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        logic [3:0] prev;
        bit         synced;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{G7, G2, G1, G3};
        state = 3'd1; score = 7'd127; lives = 2'd3;
        repeat (20) @(negedge clk);
        synced = 0;
        prev = an;
        for (int i = 0; i < 40 && !synced; i++) begin
            @(negedge clk);
            if (an === 4'b1110 && prev !== 4'b1110) synced = 1;
            prev = an;
        end
        vectors++;
        if (!synced) begin miscompares++; $display("FAIL scan_sync got=timeout exp=an 1110"); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (an !== exp_an[k]) begin miscompares++; $display("FAIL scan_an%0d got=%b exp=%b", k, an, exp_an[k]); end
            vectors++;
            if (seg !== exp_seg[k]) begin miscompares++; $display("FAIL scan_seg%0d got=%h exp=%h", k, seg, exp_seg[k]); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_blanking;
        logic [6:0] score_v [3];
        logic [6:0] exp [3][4];
        score_v = '{7'd5, 7'd10, 7'd105};
        exp[0]  = '{G5, BLK, BLK, G2};
        exp[1]  = '{G0, G1, BLK, G2};
        exp[2]  = '{G5, G0, G1, G2};
        state = 3'd1; lives = 2'd2;
        for (int v = 0; v < 3; v++) begin
            score = score_v[v];
            repeat (12) @(negedge clk);
            capture(16);
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (cap[i] !== exp[v][i]) begin
                    miscompares++;
                    $display("FAIL blank_s%0d_d%0d got=%h exp=%h", score_v[v], i, cap[i], exp[v][i]);
                end
            end
        end
    endtask

    task automatic test_midconv;
        logic [6:0] pat [3][4];
        int p, errs, hit, d;
        pat[0] = '{G5, G0, G1, G2};
        pat[1] = '{G2, G4, BLK, G2};
        pat[2] = '{G9, G9, BLK, G2};
        @(negedge clk);
        score = 7'd42;
        repeat (2) @(negedge clk);
        score = 7'd99;
        p = 0; errs = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (d < 0) begin
                errs++;
            end else begin
                hit = -1;
                for (int v = p; v < 3; v++) if (hit < 0 && pat[v][d] === seg) hit = v;
                if (hit < 0) errs++;
                else p = hit;
            end
        end
        vectors++;
        if (errs !== 0) begin miscompares++; $display("FAIL midconv_mixed got=%0d exp=0", errs); end
        vectors++;
        if (p !== 2) begin miscompares++; $display("FAIL midconv_final got=%0d exp=2", p); end
    endtask

    task automatic test_blink;
        bit exp_off;
        @(negedge clk);
        state = 3'd2;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
`ifdef WAM_DISP_BLINK_EN
            exp_off = ((k / 8) % 2) == 1;
`else
            exp_off = 1'b0;
`endif
            vectors++;
            if ((an === 4'b1111) !== exp_off) begin
                miscompares++;
                $display("FAIL blink_k%0d got=%b exp_off=%0b", k, an, exp_off);
            end
        end
    endtask

    task automatic test_reset_midconv;
        logic [6:0] exp [4];
        exp = '{G7, G7, BLK, G3};
        @(negedge clk);
        state = 3'd1; lives = 2'd3; score = 7'd77;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL rstmid_an got=%b exp=1111", an); end
        vectors++;
        if (seg !== BLK) begin miscompares++; $display("FAIL rstmid_seg got=%h exp=%h", seg, BLK); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (13) @(negedge clk);
        capture(16);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap[i] !== exp[i]) begin miscompares++; $display("FAIL rstmid_d%0d got=%h exp=%h", i, cap[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_blanking();
        test_midconv();
        test_blink();
        test_reset_midconv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
